// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the handshaked ALU control decoder: ALU operation
// codes, ALUOp field values and the output-stage FSM state type.
package alu_ctrl_pkg;

    localparam int unsigned CODE_W = 5;

    localparam logic [CODE_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [CODE_W-1:0] ALU_SUB    = 5'd1;
    localparam logic [CODE_W-1:0] ALU_AND    = 5'd2;
    localparam logic [CODE_W-1:0] ALU_OR     = 5'd3;
    localparam logic [CODE_W-1:0] ALU_XOR    = 5'd4;
    localparam logic [CODE_W-1:0] ALU_SLT    = 5'd5;
    localparam logic [CODE_W-1:0] ALU_SLTU   = 5'd6;
    localparam logic [CODE_W-1:0] ALU_SLL    = 5'd7;
    localparam logic [CODE_W-1:0] ALU_SRL    = 5'd8;
    localparam logic [CODE_W-1:0] ALU_SRA    = 5'd9;
    localparam logic [CODE_W-1:0] ALU_MUL    = 5'd16;
    localparam logic [CODE_W-1:0] ALU_MULH   = 5'd17;
    localparam logic [CODE_W-1:0] ALU_MULHSU = 5'd18;
    localparam logic [CODE_W-1:0] ALU_MULHU  = 5'd19;
    localparam logic [CODE_W-1:0] ALU_DIV    = 5'd20;
    localparam logic [CODE_W-1:0] ALU_DIVU   = 5'd21;
    localparam logic [CODE_W-1:0] ALU_REM    = 5'd22;
    localparam logic [CODE_W-1:0] ALU_REMU   = 5'd23;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_MULDIV = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational mapping of decoder fields to {ALU code, muldiv, illegal}.
// M-extension decode is present only when ALUDEC_M_EXT_EN is defined.
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic              opb5,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              funct7b0,
    input  logic [1:0]        alu_op,
    output logic [CODE_W-1:0] code_c,
    output logic              muldiv_c,
    output logic              illegal_c
);

    always_comb begin
        code_c    = ALU_ADD;
        muldiv_c  = 1'b0;
        illegal_c = 1'b0;
        unique case (alu_op)
            ALUOP_ADD: code_c = ALU_ADD;
            ALUOP_SUB: code_c = ALU_SUB;
            ALUOP_RSVD: begin
                code_c    = ALU_ADD;
                illegal_c = 1'b1;
            end
            default: begin
                if (opb5 && funct7b0) begin
`ifdef ALUDEC_M_EXT_EN
                    // M ops occupy 16..23 in funct3 order
                    code_c   = ALU_MUL | {2'b00, funct3};
                    muldiv_c = 1'b1;
`else
                    illegal_c = 1'b1;
`endif
                end else begin
                    unique case (funct3)
                        3'b000: code_c = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
                        3'b001: begin
                            code_c    = ALU_SLL;
                            illegal_c = funct7b5;
                        end
                        3'b010: code_c = ALU_SLT;
                        3'b011: code_c = ALU_SLTU;
                        3'b100: code_c = ALU_XOR;
                        3'b101: code_c = funct7b5 ? ALU_SRA : ALU_SRL;
                        3'b110: code_c = ALU_OR;
                        default: code_c = ALU_AND;
                    endcase
                    // funct7b5 is only meaningful for R-type on add/sub and shifts-right
                    if (opb5 && funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
                        code_c    = ALU_ADD;
                        illegal_c = 1'b1;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_mc.sv
// ALU control decoder with a one-entry valid/ready output stage; mul/div ops
// hold off out_valid for MULDIV_CYCLES when ALUDEC_M_EXT_EN is defined.
module alu_ctrl_mc
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_W        = 5,
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              opb5,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              funct7b0,
    input  logic [1:0]        ALUOp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              muldiv,
    output logic              illegal,
    output logic              busy
);

    if (CTRL_W < CODE_W) begin : g_bad_ctrl_w
        $error("alu_ctrl_mc: CTRL_W must be >= 5");
    end
    if (MULDIV_CYCLES < 1) begin : g_bad_cycles
        $error("alu_ctrl_mc: MULDIV_CYCLES must be >= 1");
    end

    logic [CODE_W-1:0] dec_code;
    logic              dec_muldiv;
    logic              dec_illegal;

    alu_op_decode u_dec (
        .opb5      (opb5),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .funct7b0  (funct7b0),
        .alu_op    (ALUOp),
        .code_c    (dec_code),
        .muldiv_c  (dec_muldiv),
        .illegal_c (dec_illegal)
    );

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              muldiv_q, muldiv_d;
    logic              illegal_q, illegal_d;

`ifdef ALUDEC_M_EXT_EN
    localparam int unsigned CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Wait counter for the iterative unit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    // State and output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            muldiv_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            muldiv_q  <= muldiv_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state, handshake and payload capture
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        muldiv_d  = muldiv_q;
        illegal_d = illegal_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef ALUDEC_M_EXT_EN
        cnt_d     = cnt_q;
        busy      = 1'b0;
`endif
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = S_IDLE;
            end
`ifdef ALUDEC_M_EXT_EN
            S_MULDIV: begin
                busy = 1'b1;
                if (cnt_q == '0) state_d = S_HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (in_valid && in_ready) begin
            ctrl_d    = CTRL_W'(dec_code);
            muldiv_d  = dec_muldiv;
            illegal_d = dec_illegal;
            state_d   = S_HOLD;
`ifdef ALUDEC_M_EXT_EN
            if (dec_muldiv) begin
                state_d = S_MULDIV;
                cnt_d   = CNT_LOAD;
            end
`endif
        end
    end

`ifndef ALUDEC_M_EXT_EN
    assign busy = 1'b0;
`endif

    assign ALUControl = ctrl_q;
    assign muldiv     = muldiv_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Directed testbench for alu_ctrl_mc; follows ALUDEC_M_EXT_EN to pick the
// expected mul/div behaviour.
module tb_alu_ctrl_mc;

    localparam int unsigned CTRL_W = 5;
    localparam int unsigned MDC    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic              opb5;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic              funct7b0;
    logic [1:0]        ALUOp;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] ALUControl;
    logic              muldiv;
    logic              illegal;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_ctrl_mc #(.CTRL_W(CTRL_W), .MULDIV_CYCLES(MDC)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opb5       (opb5),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .funct7b0   (funct7b0),
        .ALUOp      (ALUOp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUControl (ALUControl),
        .muldiv     (muldiv),
        .illegal    (illegal),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic o5, input logic [2:0] f3,
                         input logic f75, input logic f70);
        in_valid = 1'b1;
        ALUOp    = op;
        opb5     = o5;
        funct3   = f3;
        funct7b5 = f75;
        funct7b0 = f70;
    endtask

    // One accepted op with out_ready high; result checked one cycle later
    task automatic run_vec(input string tag, input logic [1:0] op, input logic o5,
                           input logic [2:0] f3, input logic f75, input logic f70,
                           input logic [4:0] exp_code, input logic exp_ill);
        drive(op, o5, f3, f75, f70);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".code"}, 32'(ALUControl), 32'(exp_code));
        check({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
        check({tag, ".muldiv"}, 32'(muldiv), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'd0);
        check({tag, ".code"}, 32'(ALUControl), 32'd0);
        check({tag, ".muldiv"}, 32'(muldiv), 32'd0);
        check({tag, ".illegal"}, 32'(illegal), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
        in_valid  = 1'b0;
        tick();
        tick();
        check_cleared("rst");
        reset = 1'b1;
        tick();
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.valid_after", 32'(out_valid), 32'd0);

        // addi with immediate bit 30 set stays ADD
        run_vec("addi", 2'b10, 1'b0, 3'b000, 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        check("addi.idle", 32'(out_valid), 32'd0);

        // back-to-back sub then srai
        drive(2'b01, 1'b0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(2'b10, 1'b0, 3'b101, 1'b1, 1'b0);
        check("b2b.sub_code", 32'(ALUControl), 32'd1);
        check("b2b.sub_valid", 32'(out_valid), 32'd1);
        check("b2b.in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("b2b.srai_code", 32'(ALUControl), 32'd9);
        check("b2b.srai_valid", 32'(out_valid), 32'd1);

        // decode table, issued back to back
        run_vec("sub_r",  2'b10, 1'b1, 3'b000, 1'b1, 1'b0, 5'd1, 1'b0);
        run_vec("add_r",  2'b10, 1'b1, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0);
        run_vec("sll_r",  2'b10, 1'b1, 3'b001, 1'b0, 1'b0, 5'd7, 1'b0);
        run_vec("slli_b", 2'b10, 1'b0, 3'b001, 1'b1, 1'b0, 5'd7, 1'b1);
        run_vec("slt_r",  2'b10, 1'b1, 3'b010, 1'b0, 1'b0, 5'd5, 1'b0);
        run_vec("sltiu",  2'b10, 1'b0, 3'b011, 1'b0, 1'b0, 5'd6, 1'b0);
        run_vec("xori_h", 2'b10, 1'b0, 3'b100, 1'b1, 1'b0, 5'd4, 1'b0);
        run_vec("srl_r",  2'b10, 1'b1, 3'b101, 1'b0, 1'b0, 5'd8, 1'b0);
        run_vec("sra_r",  2'b10, 1'b1, 3'b101, 1'b1, 1'b0, 5'd9, 1'b0);
        run_vec("and_r",  2'b10, 1'b1, 3'b111, 1'b0, 1'b0, 5'd2, 1'b0);
        run_vec("aluop0", 2'b00, 1'b1, 3'b111, 1'b1, 1'b0, 5'd0, 1'b0);
        run_vec("rsvd",   2'b11, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b1);
        run_vec("xor_b",  2'b10, 1'b1, 3'b100, 1'b1, 1'b0, 5'd0, 1'b1);
        run_vec("slt_b",  2'b10, 1'b1, 3'b010, 1'b1, 1'b0, 5'd0, 1'b1);
        tick();
        check("tbl.idle", 32'(out_valid), 32'd0);

`ifdef ALUDEC_M_EXT_EN
        // mul: busy window of MDC cycles, then result
        drive(2'b10, 1'b1, 3'b000, 1'b0, 1'b1);
        tick();
        in_valid = 1'b1;
        for (int k = 0; k < int'(MDC); k++) begin
            check($sformatf("mul.busy%0d", k), 32'(busy), 32'd1);
            check($sformatf("mul.in_ready%0d", k), 32'(in_ready), 32'd0);
            check($sformatf("mul.valid%0d", k), 32'(out_valid), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        check("mul.valid", 32'(out_valid), 32'd1);
        check("mul.code", 32'(ALUControl), 32'd16);
        check("mul.muldiv", 32'(muldiv), 32'd1);
        check("mul.busy_end", 32'(busy), 32'd0);
        tick();
        // remu lands on the top M code
        drive(2'b10, 1'b1, 3'b111, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < int'(MDC); k++) tick();
        check("remu.valid", 32'(out_valid), 32'd1);
        check("remu.code", 32'(ALUControl), 32'd23);
        check("remu.muldiv", 32'(muldiv), 32'd1);
        tick();
`else
        // without M decode, mul is an illegal ADD with normal latency
        run_vec("mul_off", 2'b10, 1'b1, 3'b000, 1'b0, 1'b1, 5'd0, 1'b1);
        check("mul_off.busy", 32'(busy), 32'd0);
        tick();
`endif
        check("m.idle", 32'(out_valid), 32'd0);

        // backpressure on an or op; a pending xor waits for the slot
        out_ready = 1'b0;
        drive(2'b10, 1'b1, 3'b110, 1'b0, 1'b0);
        tick();
        drive(2'b10, 1'b1, 3'b100, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp.valid%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("bp.code%0d", k), 32'(ALUControl), 32'd3);
            check($sformatf("bp.in_ready%0d", k), 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(in_ready), 32'd1);
        check("bp.release_code", 32'(ALUControl), 32'd3);
        tick();
        in_valid = 1'b0;
        check("bp.next_code", 32'(ALUControl), 32'd4);
        check("bp.next_valid", 32'(out_valid), 32'd1);
        tick();
        check("bp.idle", 32'(out_valid), 32'd0);

        // reset with an op in flight, then no stale output afterwards
`ifdef ALUDEC_M_EXT_EN
        drive(2'b10, 1'b1, 3'b001, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        check("mrst.busy_pre", 32'(busy), 32'd1);
`else
        out_ready = 1'b0;
        drive(2'b11, 1'b1, 3'b110, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("mrst.valid_pre", 32'(out_valid), 32'd1);
`endif
        reset = 1'b0;
        #1;
        check_cleared("mrst");
        tick();
        out_ready = 1'b1;
        reset = 1'b1;
        tick();
        check("mrst.in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < int'(MDC) + 2; k++) begin
            check($sformatf("mrst.stale%0d", k), 32'(out_valid), 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
